div_sqrt_issue: RTL and testbench
=================================

Name: div_sqrt_issue

Overview:
- Request-side controller that drives the shared divide/square-root unit's start/ready/done interface.
- Accepts one operation at a time from the FPU issue stage over a valid/ready handshake and launches it into the unit with a single-cycle start pulse.
- Captures the result and flags on done, then returns them with a tag over a second valid/ready handshake.
- Includes a watchdog that returns an error result if the unit never signals done.

Parameters:
- C_OP, 32, operand/result width.
- C_RM, 3, rounding-mode width.
- TAG_WIDTH, 4, width of the request tag carried through to the response.
- TIMEOUT, 64, maximum cycles in WAIT before the watchdog fires; legal range 1..1023.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous, active-high reset.
- In_valid_SI  in  1  request valid.
- In_ready_SO  out  1  request accepted this cycle when high together with In_valid_SI.
- In_sqrt_SI  in  1  0 = divide a/b, 1 = sqrt a.
- In_operand_a_DI  in  C_OP  operand a.
- In_operand_b_DI  in  C_OP  operand b; ignored for sqrt.
- In_rm_DI  in  C_RM  rounding mode.
- In_tag_DI  in  TAG_WIDTH  request tag.
- Div_start_SO  out  1  one-cycle divide start to the unit.
- Sqrt_start_SO  out  1  one-cycle sqrt start to the unit.
- Operand_a_DO  out  C_OP  operand a to the unit.
- Operand_b_DO  out  C_OP  operand b to the unit.
- RM_SO  out  C_RM  rounding mode to the unit.
- Unit_ready_SI  in  1  unit can accept a start.
- Unit_done_SI  in  1  unit result valid (one-cycle pulse).
- Unit_result_DI  in  32  unit result.
- Unit_exp_of_SI  in  1  overflow flag from the unit.
- Unit_exp_uf_SI  in  1  underflow flag from the unit.
- Unit_div_zero_SI  in  1  divide-by-zero flag from the unit.
- Out_valid_SO  out  1  response valid.
- Out_ready_SI  in  1  response consumer ready.
- Out_result_DO  out  32  result.
- Out_flags_DO  out  4  {timeout, div_zero, exp_uf, exp_of}.
- Out_tag_DO  out  TAG_WIDTH  tag of the request.
- Busy_SO  out  1  high in every state except IDLE.

Behaviour:
- Reset (Rst_RI high at a clock edge):
  - FSM goes to IDLE.
  - Div_start_SO, Sqrt_start_SO, Out_valid_SO and Busy_SO go to 0.
  - Operand, RM, result, flag and tag registers clear to 0; watchdog counter clears to 0.
  - Reset during ISSUE, WAIT or HOLD abandons the operation; no response is produced.
  - A later Unit_done_SI from the abandoned operation arrives in IDLE and is ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - In_ready_SO = 1.
  - On In_valid_SI, register sqrt/a/b/rm/tag and go to ISSUE.
- ISSUE:
  - In_ready_SO = 0.
  - If Unit_ready_SI = 1, assert exactly one of Div_start_SO or Sqrt_start_SO for that single cycle, then go to WAIT.
  - Otherwise stay in ISSUE with both start signals low.
- WAIT:
  - The watchdog counter increments every cycle.
  - On Unit_done_SI, capture Unit_result_DI and the three flags, set timeout = 0, go to HOLD.
  - If the counter reaches TIMEOUT with no done, capture result 0x7FC00000 and flags 4'b1000, then go to HOLD.
  - If done arrives in the same cycle the counter reaches TIMEOUT, done wins.
- HOLD:
  - Out_valid_SO = 1.
  - In_ready_SO = Out_ready_SI; this path is combinational.
  - On Out_ready_SI with In_valid_SI: complete the response, accept the new request and go to ISSUE.
  - On Out_ready_SI without In_valid_SI: go to IDLE.
  - Without Out_ready_SI: hold; response outputs stay stable.
- Unit interface rules:
  - Operand_a_DO, Operand_b_DO and RM_SO are the registered request values.
  - They stay stable from ISSUE entry until the next request is accepted.
  - Unit_done_SI in IDLE, ISSUE or HOLD is ignored.
  - Div_start_SO and Sqrt_start_SO are never both high.
  - At most one operation is in flight at any time.
- Latency:
  - Accept at edge T; start asserted in cycle T+1 if Unit_ready_SI = 1.
  - Out_valid_SO rises the cycle after the Unit_done_SI cycle.
  - Minimum request-to-response overhead is 2 cycles plus the unit latency.
- Watchdog counter: width = clog2(TIMEOUT+1); it cannot wrap; it clears on entry to ISSUE.

Test Plan:
- Divide, no stall: a=0x40400000 (3.0), b=0x3F800000 (1.0), tag 5; unit ready; done after 12 cycles with 0x40400000.
  - Required: one Div_start_SO pulse in cycle T+1; Out_valid_SO the cycle after done; result 0x40400000, flags 0, tag 5.
- Sqrt with unit not ready: Unit_ready_SI low for 3 cycles.
  - Required: FSM stays in ISSUE with starts low; a single Sqrt_start_SO pulse when ready rises; operands stable throughout.
- Response backpressure: Out_ready_SI low for 4 cycles after done.
  - Required: Out_valid_SO and result/flags/tag held stable; In_ready_SO = 0 during the stall.
- Back-to-back in HOLD: Out_ready_SI = 1 and a new request (tag 6) presented in the same cycle.
  - Required: response tag 5 completes, tag 6 is accepted in that cycle, FSM goes to ISSUE, no idle bubble.
- Watchdog: TIMEOUT=8 and no done.
  - Required: response after 8 WAIT cycles with result 0x7FC00000, flags 4'b1000.
  - Corner: done exactly on cycle 8 returns the unit's result.
- Reset in WAIT, then a stray done.
  - Required: all outputs 0, no response; a new request afterwards completes normally.

Source files
------------

// File: rtl/div_sqrt_issue_if.sv
// rtl/div_sqrt_issue_if.sv - request, unit and response signals of the div/sqrt issue controller
// slave is the controller's view; master is the view of whoever surrounds it.
interface div_sqrt_issue_if #(
  parameter int C_OP      = 32,
  parameter int C_RM      = 3,
  parameter int TAG_WIDTH = 4
);
  logic                 In_valid_SI;
  logic                 In_ready_SO;
  logic                 In_sqrt_SI;
  logic [C_OP-1:0]      In_operand_a_DI;
  logic [C_OP-1:0]      In_operand_b_DI;
  logic [C_RM-1:0]      In_rm_DI;
  logic [TAG_WIDTH-1:0] In_tag_DI;
  logic                 Div_start_SO;
  logic                 Sqrt_start_SO;
  logic [C_OP-1:0]      Operand_a_DO;
  logic [C_OP-1:0]      Operand_b_DO;
  logic [C_RM-1:0]      RM_SO;
  logic                 Unit_ready_SI;
  logic                 Unit_done_SI;
  logic [31:0]          Unit_result_DI;
  logic                 Unit_exp_of_SI;
  logic                 Unit_exp_uf_SI;
  logic                 Unit_div_zero_SI;
  logic                 Out_valid_SO;
  logic                 Out_ready_SI;
  logic [31:0]          Out_result_DO;
  logic [3:0]           Out_flags_DO;
  logic [TAG_WIDTH-1:0] Out_tag_DO;
  logic                 Busy_SO;

  modport slave (
    input  In_valid_SI, In_sqrt_SI, In_operand_a_DI, In_operand_b_DI, In_rm_DI, In_tag_DI,
    input  Unit_ready_SI, Unit_done_SI, Unit_result_DI, Unit_exp_of_SI, Unit_exp_uf_SI,
    input  Unit_div_zero_SI, Out_ready_SI,
    output In_ready_SO, Div_start_SO, Sqrt_start_SO, Operand_a_DO, Operand_b_DO, RM_SO,
    output Out_valid_SO, Out_result_DO, Out_flags_DO, Out_tag_DO, Busy_SO
  );

  modport master (
    output In_valid_SI, In_sqrt_SI, In_operand_a_DI, In_operand_b_DI, In_rm_DI, In_tag_DI,
    output Unit_ready_SI, Unit_done_SI, Unit_result_DI, Unit_exp_of_SI, Unit_exp_uf_SI,
    output Unit_div_zero_SI, Out_ready_SI,
    input  In_ready_SO, Div_start_SO, Sqrt_start_SO, Operand_a_DO, Operand_b_DO, RM_SO,
    input  Out_valid_SO, Out_result_DO, Out_flags_DO, Out_tag_DO, Busy_SO
  );
endinterface

// File: rtl/div_sqrt_issue.sv
// rtl/div_sqrt_issue.sv - issues one div/sqrt operation at a time and returns its tagged result
// A watchdog substitutes a quiet-NaN timeout response if the unit never signals done.
module div_sqrt_issue #(
  parameter int C_OP      = 32,
  parameter int C_RM      = 3,
  parameter int TAG_WIDTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic            Clk_CI,
  input  logic            Rst_RI,
  div_sqrt_issue_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic                 sqrt_q;
  logic [C_OP-1:0]      a_q, b_q;
  logic [C_RM-1:0]      rm_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [31:0]          result_q;
  logic [3:0]           flags_q;
  logic [CW-1:0]        cnt_q;
  logic                 in_ready, div_start, sqrt_start, out_valid, accept;

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    div_start  = 1'b0;
    sqrt_start = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.In_valid_SI) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.Unit_ready_SI) begin
          div_start  = ~sqrt_q;
          sqrt_start = sqrt_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.Unit_done_SI || cnt_q == CNT_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = bus.Out_ready_SI;
        if (bus.Out_ready_SI) state_d = bus.In_valid_SI ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_ready & bus.In_valid_SI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= S_IDLE;
      sqrt_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      tag_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sqrt_q <= bus.In_sqrt_SI;
        a_q    <= bus.In_operand_a_DI;
        b_q    <= bus.In_operand_b_DI;
        rm_q   <= bus.In_rm_DI;
        tag_q  <= bus.In_tag_DI;
        cnt_q  <= '0;
      end else if (state_q == S_WAIT) begin
        // Leaving WAIT at CNT_LAST caps the count at TIMEOUT, so it never wraps.
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_WAIT) begin
        if (bus.Unit_done_SI) begin
          result_q <= bus.Unit_result_DI;
          flags_q  <= {1'b0, bus.Unit_div_zero_SI, bus.Unit_exp_uf_SI, bus.Unit_exp_of_SI};
        end else if (cnt_q == CNT_LAST) begin
          result_q <= 32'h7FC0_0000;
          flags_q  <= 4'b1000;
        end
      end
    end
  end

  assign bus.In_ready_SO   = in_ready;
  assign bus.Div_start_SO  = div_start;
  assign bus.Sqrt_start_SO = sqrt_start;
  assign bus.Operand_a_DO  = a_q;
  assign bus.Operand_b_DO  = b_q;
  assign bus.RM_SO         = rm_q;
  assign bus.Out_valid_SO  = out_valid;
  assign bus.Out_result_DO = result_q;
  assign bus.Out_flags_DO  = flags_q;
  assign bus.Out_tag_DO    = tag_q;
  assign bus.Busy_SO       = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_sqrt_issue.sv
// tb/tb_div_sqrt_issue.sv - directed bench for div_sqrt_issue
// A second instance with TIMEOUT=8 shares the stimulus and covers the watchdog.
module tb_div_sqrt_issue;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   div_pulses = 0;
  int   sqrt_pulses = 0;

  always #5 clk = ~clk;

  div_sqrt_issue_if #(.C_OP(32), .C_RM(3), .TAG_WIDTH(4)) bus ();
  div_sqrt_issue_if #(.C_OP(32), .C_RM(3), .TAG_WIDTH(4)) bus_wd ();

  assign bus_wd.In_valid_SI      = bus.In_valid_SI;
  assign bus_wd.In_sqrt_SI       = bus.In_sqrt_SI;
  assign bus_wd.In_operand_a_DI  = bus.In_operand_a_DI;
  assign bus_wd.In_operand_b_DI  = bus.In_operand_b_DI;
  assign bus_wd.In_rm_DI         = bus.In_rm_DI;
  assign bus_wd.In_tag_DI        = bus.In_tag_DI;
  assign bus_wd.Unit_ready_SI    = bus.Unit_ready_SI;
  assign bus_wd.Unit_done_SI     = bus.Unit_done_SI;
  assign bus_wd.Unit_result_DI   = bus.Unit_result_DI;
  assign bus_wd.Unit_exp_of_SI   = bus.Unit_exp_of_SI;
  assign bus_wd.Unit_exp_uf_SI   = bus.Unit_exp_uf_SI;
  assign bus_wd.Unit_div_zero_SI = bus.Unit_div_zero_SI;
  assign bus_wd.Out_ready_SI     = bus.Out_ready_SI;

  div_sqrt_issue #(.C_OP(32), .C_RM(3), .TAG_WIDTH(4), .TIMEOUT(64)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .bus(bus.slave)
  );
  div_sqrt_issue #(.C_OP(32), .C_RM(3), .TAG_WIDTH(4), .TIMEOUT(8)) dut_wd (
    .Clk_CI(clk), .Rst_RI(rst), .bus(bus_wd.slave)
  );

  always @(posedge clk) begin
    if (bus.Div_start_SO)  div_pulses  <= div_pulses + 1;
    if (bus.Sqrt_start_SO) sqrt_pulses <= sqrt_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic request(input logic sqrt, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [3:0] tag);
    bus.In_valid_SI     = 1'b1;
    bus.In_sqrt_SI      = sqrt;
    bus.In_operand_a_DI = a;
    bus.In_operand_b_DI = b;
    bus.In_rm_DI        = rm;
    bus.In_tag_DI       = tag;
  endtask

  initial begin
    rst = 1'b1;
    bus.In_valid_SI = 0; bus.In_sqrt_SI = 0; bus.In_operand_a_DI = 0; bus.In_operand_b_DI = 0;
    bus.In_rm_DI = 0; bus.In_tag_DI = 0; bus.Unit_ready_SI = 1; bus.Unit_done_SI = 0;
    bus.Unit_result_DI = 0; bus.Unit_exp_of_SI = 0; bus.Unit_exp_uf_SI = 0;
    bus.Unit_div_zero_SI = 0; bus.Out_ready_SI = 1;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", bus.In_ready_SO, 1);
    check("rst_busy", bus.Busy_SO, 0);
    check("rst_out_valid", bus.Out_valid_SO, 0);
    check("rst_result", bus.Out_result_DO, 0);
    check("rst_tag", bus.Out_tag_DO, 0);

    // divide 3.0 / 1.0, tag 5, done 12 cycles into WAIT
    request(0, 32'h4040_0000, 32'h3F80_0000, 3'd0, 4'd5);
    step();
    bus.In_valid_SI = 0;
    check("div_start_t1", bus.Div_start_SO, 1);
    check("div_sqrt_start_t1", bus.Sqrt_start_SO, 0);
    check("div_issue_in_ready", bus.In_ready_SO, 0);
    check("div_operand_a", bus.Operand_a_DO, 32'h4040_0000);
    step();
    check("div_start_dropped", bus.Div_start_SO, 0);
    repeat (11) step();
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'h4040_0000;
    check("div_valid_in_done_cycle", bus.Out_valid_SO, 0);
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0;
    check("div_out_valid", bus.Out_valid_SO, 1);
    check("div_result", bus.Out_result_DO, 32'h4040_0000);
    check("div_flags", bus.Out_flags_DO, 0);
    check("div_tag", bus.Out_tag_DO, 5);
    step();
    check("div_idle_valid", bus.Out_valid_SO, 0);
    check("div_idle_busy", bus.Busy_SO, 0);
    check("div_pulse_count", div_pulses, 1);

    // sqrt with the unit not ready for 3 cycles, then 4 cycles of response backpressure
    bus.Unit_ready_SI = 0; bus.Out_ready_SI = 0;
    request(1, 32'h4080_0000, 32'hDEAD_BEEF, 3'd3, 4'd5);
    step();
    bus.In_valid_SI = 0;
    for (int i = 0; i < 3; i++) begin
      check("sqrt_stall_sqrt_start", bus.Sqrt_start_SO, 0);
      check("sqrt_stall_div_start", bus.Div_start_SO, 0);
      check("sqrt_stall_busy", bus.Busy_SO, 1);
      check("sqrt_stall_operand_a", bus.Operand_a_DO, 32'h4080_0000);
      step();
    end
    bus.Unit_ready_SI = 1;
    #1;
    check("sqrt_start_on_ready", bus.Sqrt_start_SO, 1);
    check("sqrt_no_div_start", bus.Div_start_SO, 0);
    step();
    check("sqrt_start_dropped", bus.Sqrt_start_SO, 0);
    check("sqrt_pulse_count", sqrt_pulses, 1);
    step();
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'h4000_0000; bus.Unit_exp_of_SI = 1;
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0; bus.Unit_exp_of_SI = 0;
    request(0, 32'h4100_0000, 32'h4000_0000, 3'd1, 4'd6);
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", bus.Out_valid_SO, 1);
      check("bp_result", bus.Out_result_DO, 32'h4000_0000);
      check("bp_flags", bus.Out_flags_DO, 4'b0001);
      check("bp_tag", bus.Out_tag_DO, 5);
      check("bp_in_ready", bus.In_ready_SO, 0);
      step();
    end

    // back-to-back: tag 5 completes while tag 6 is accepted in the same cycle
    bus.Out_ready_SI = 1;
    #1;
    check("b2b_in_ready", bus.In_ready_SO, 1);
    check("b2b_old_tag", bus.Out_tag_DO, 5);
    step();
    bus.In_valid_SI = 0;
    check("b2b_busy", bus.Busy_SO, 1);
    check("b2b_out_valid_low", bus.Out_valid_SO, 0);
    check("b2b_div_start", bus.Div_start_SO, 1);
    check("b2b_operand_a", bus.Operand_a_DO, 32'h4100_0000);
    check("b2b_rm", bus.RM_SO, 1);
    step();
    step();
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'h7F80_0000; bus.Unit_div_zero_SI = 1;
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0; bus.Unit_div_zero_SI = 0;
    check("b2b_result", bus.Out_result_DO, 32'h7F80_0000);
    check("b2b_flags", bus.Out_flags_DO, 4'b0100);
    check("b2b_tag", bus.Out_tag_DO, 6);
    step();
    check("b2b_idle", bus.Busy_SO, 0);

    // watchdog on the TIMEOUT=8 instance
    rst = 1; step(); rst = 0;
    request(0, 32'h4040_0000, 32'h0000_0000, 3'd0, 4'd7);
    step();
    bus.In_valid_SI = 0;
    step();
    repeat (7) step();
    check("wd_not_yet", bus_wd.Out_valid_SO, 0);
    step();
    check("wd_out_valid", bus_wd.Out_valid_SO, 1);
    check("wd_result", bus_wd.Out_result_DO, 32'h7FC0_0000);
    check("wd_flags", bus_wd.Out_flags_DO, 4'b1000);
    check("wd_tag", bus_wd.Out_tag_DO, 7);
    step();
    request(0, 32'h4040_0000, 32'h3F80_0000, 3'd0, 4'd8);
    step();
    bus.In_valid_SI = 0;
    step();
    repeat (7) step();
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'h1234_5678; bus.Unit_exp_uf_SI = 1;
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0; bus.Unit_exp_uf_SI = 0;
    check("wd_corner_valid", bus_wd.Out_valid_SO, 1);
    check("wd_corner_result", bus_wd.Out_result_DO, 32'h1234_5678);
    check("wd_corner_flags", bus_wd.Out_flags_DO, 4'b0010);
    check("wd_corner_tag", bus_wd.Out_tag_DO, 8);
    step();

    // reset during WAIT, then a stray done
    rst = 1; step(); rst = 0;
    request(0, 32'h4040_0000, 32'h3F80_0000, 3'd2, 4'd9);
    step();
    bus.In_valid_SI = 0;
    step(); step(); step();
    rst = 1; step(); rst = 0;
    check("rw_out_valid", bus.Out_valid_SO, 0);
    check("rw_busy", bus.Busy_SO, 0);
    check("rw_div_start", bus.Div_start_SO, 0);
    check("rw_result", bus.Out_result_DO, 0);
    check("rw_flags", bus.Out_flags_DO, 0);
    check("rw_tag", bus.Out_tag_DO, 0);
    check("rw_operand_a", bus.Operand_a_DO, 0);
    check("rw_operand_b", bus.Operand_b_DO, 0);
    check("rw_rm", bus.RM_SO, 0);
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'hAAAA_5555;
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0;
    check("stray_out_valid", bus.Out_valid_SO, 0);
    check("stray_busy", bus.Busy_SO, 0);
    check("stray_result", bus.Out_result_DO, 0);
    request(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 4'd10);
    step();
    bus.In_valid_SI = 0;
    step(); step();
    bus.Unit_done_SI = 1; bus.Unit_result_DI = 32'h3F80_0000;
    step();
    bus.Unit_done_SI = 0; bus.Unit_result_DI = 0;
    check("after_rst_valid", bus.Out_valid_SO, 1);
    check("after_rst_result", bus.Out_result_DO, 32'h3F80_0000);
    check("after_rst_tag", bus.Out_tag_DO, 10);
    check("after_rst_flags", bus.Out_flags_DO, 0);
    step();
    check("after_rst_idle", bus.Busy_SO, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
